// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed 7-segment driver. The display data is double-buffered:
// loads land in a pending buffer that is promoted to the active buffer only
// at a frame boundary. Each digit slot starts with a ghosting blank. The
// blank is the only time the shared segment bus may change. Leading zeros can
// be suppressed.
module seg7_scan_driver #(
  parameter int NUM_DIG     = 7,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b0,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [4*NUM_DIG-1:0] digits_in,
  input  logic [NUM_DIG-1:0]   blank_in,
  output logic [NUM_DIG-1:0]   trans,
  output logic [6:0]           led7seg,
  output logic                 frame_done,
  output logic                 load_ack
);

  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  localparam logic [6:0]         SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIG-1:0] TRANS_OFF = DIG_ACT_LOW ? {NUM_DIG{1'b1}} : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4*NUM_DIG-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIG-1:0]   act_blank_q, act_blank_d;
  logic [4*NUM_DIG-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIG-1:0]   pend_blank_q, pend_blank_d;
  logic                 pend_vld_q, pend_vld_d;

  logic [NUM_DIG-1:0] trans_q, trans_d;
  logic [6:0]         seg_q, seg_d;
  logic               frame_done_q, frame_done_d;
  logic               load_ack_q, load_ack_d;

  // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h00;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Per-digit views of the active buffer: the nibble, and whether this digit
  // and every more-significant digit are zero (leading-zero candidate).
  logic [3:0]         nib [NUM_DIG];
  logic [NUM_DIG-1:0] zero_up;
  logic [NUM_DIG-1:0] dig_on;

  for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_digit
    assign nib[gi]     = act_dig_q[4*gi +: 4];
    assign zero_up[gi] = ~|act_dig_q[4*NUM_DIG-1:4*gi];
    assign dig_on[gi]  = (state_d == S_ON) && (idx_d == IDX_W'(gi));
  end

  // Slot sequencing: IDLE -> BLANK -> ON -> BLANK(idx+1) ..., en=0 parks in IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = S_ON;
        end
        S_ON: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Buffer handoff and registered output values. The frame boundary is the
  // edge that enters the last ON cycle of the last digit: frame_done and
  // load_ack rise together there. Segments only reload when entering or
  // staying in BLANK, so an active-buffer swap never shows mid-slot.
  always_comb begin
    logic       dark;
    logic [6:0] lit;

    act_dig_d    = act_dig_q;
    act_blank_d  = act_blank_q;
    pend_dig_d   = pend_dig_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    load_ack_d   = 1'b0;

    frame_done_d = (state_d == S_ON) && (idx_d == IDX_LAST) && (cnt_d == SLOT_LAST);

    if (frame_done_d) begin
      if (load) begin
        act_dig_d   = digits_in;
        act_blank_d = blank_in;
        load_ack_d  = 1'b1;
      end else if (pend_vld_q) begin
        act_dig_d   = pend_dig_q;
        act_blank_d = pend_blank_q;
        load_ack_d  = 1'b1;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_dig_d   = digits_in;
      pend_blank_d = blank_in;
      pend_vld_d   = 1'b1;
    end

    dark = act_blank_q[idx_d] ||
           (LZ_SUPPRESS && (idx_d != '0) && zero_up[idx_d]);
    lit  = dark ? 7'h00 : hex_to_seg(nib[idx_d]);

    seg_d = seg_q;
    if (state_d == S_IDLE) begin
      seg_d = SEG_OFF;
    end else if (state_d == S_BLANK) begin
      seg_d = SEG_ACT_LOW ? ~lit : lit;
    end

    trans_d = DIG_ACT_LOW ? ~dig_on : dig_on;
  end

  // State, buffers and outputs, with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      act_dig_q    <= '0;
      act_blank_q  <= {NUM_DIG{1'b1}};
      pend_dig_q   <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
      trans_q      <= TRANS_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_dig_q    <= act_dig_d;
      act_blank_q  <= act_blank_d;
      pend_dig_q   <= pend_dig_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      trans_q      <= trans_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign trans      = trans_q;
  assign led7seg    = seg_q;
  assign frame_done = frame_done_q;
  assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle blank).
// A phase-based reference predicts every output cycle; predictions are
// queued at drive time and popped when the DUT output is sampled.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  trans;
  logic [6:0]  led7seg;
  logic        frame_done;
  logic        load_ack;

  seg7_scan_driver #(
    .NUM_DIG(4), .SCAN_DIV(8), .BLANK_CYC(2),
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b0), .LZ_SUPPRESS(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .digits_in(digits_in), .blank_in(blank_in),
    .trans(trans), .led7seg(led7seg),
    .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] trans;
    logic [6:0] seg;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_tag = "init";

  // reference state: k = cycle within a 32-cycle frame
  int          k = 0;
  bit          running = 1'b0;
  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_blank, m_pend_blank;
  bit          m_pend_vld;
  logic [6:0]  m_seg;

  // Expected active-low segment bus for digit pos of a buffer
  function automatic logic [6:0] glyph(input logic [15:0] d, input logic [3:0] b, input int pos);
    logic [6:0] lit;
    logic [3:0] h;
    bit dark;
    bit allz;
    h = d[4*pos +: 4];
    case (h)
      4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
    endcase
    dark = b[pos];
    if (pos != 0) begin
      allz = 1'b1;
      for (int j = pos; j < 4; j++) if (d[4*j +: 4] != 4'h0) allz = 1'b0;
      if (allz) dark = 1'b1;
    end
    return dark ? 7'h7F : ~lit;
  endfunction

  task automatic model_reset();
    running     = 1'b0;
    k           = 0;
    m_act_dig   = '0;
    m_act_blank = 4'hF;
    m_pend_vld  = 1'b0;
    m_seg       = 7'h7F;
  endtask

  // Predict the outputs after the next clock edge given the current inputs
  task automatic model_edge(output exp_t e);
    int slot;
    int pos;
    e = '{trans: 4'b0, seg: 7'h7F, fd: 1'b0, ack: 1'b0};
    if (!rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      running = 1'b0;
      k       = 0;
      if (load) begin
        m_pend_dig = digits_in; m_pend_blank = blank_in; m_pend_vld = 1'b1;
      end
      m_seg = 7'h7F;
      return;
    end
    k       = running ? (k + 1) % 32 : 0;
    running = 1'b1;
    if (k == 31) begin
      e.fd = 1'b1;
      if (load) begin
        m_act_dig = digits_in; m_act_blank = blank_in; e.ack = 1'b1;
      end else if (m_pend_vld) begin
        m_act_dig = m_pend_dig; m_act_blank = m_pend_blank; e.ack = 1'b1;
      end
      m_pend_vld = 1'b0;
    end else if (load) begin
      m_pend_dig = digits_in; m_pend_blank = blank_in; m_pend_vld = 1'b1;
    end
    slot = k / 8;
    pos  = k % 8;
    e.trans = (pos < 2) ? 4'b0000 : 4'(1 << slot);
    if (pos < 2) m_seg = glyph(m_act_dig, m_act_blank, slot);
    e.seg = m_seg;
  endtask

  task automatic chk(input string name, input logic [6:0] obs, input logic [6:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s/%s k=%0d observed=%h expected=%h", cur_tag, name, k, obs, expv);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb_q.pop_front();
    chk("trans", {3'b0, trans}, {3'b0, e.trans});
    chk("led7seg", led7seg, e.seg);
    chk("frame_done", {6'b0, frame_done}, {6'b0, e.fd});
    chk("load_ack", {6'b0, load_ack}, {6'b0, e.ack});
    if (e.ack) $display("txn %s: load_ack with frame_done at %0t", cur_tag, $time);
  endtask

  task automatic step();
    exp_t e;
    model_edge(e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the next edge is the frame boundary (bounded)
  task automatic run_to_boundary();
    int guard;
    guard = 0;
    while (!(running && k == 30) && guard < 64) begin
      step();
      guard++;
    end
    chk("boundary_reached", {6'b0, (running && k == 30)}, 7'd1);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] b);
    load = 1'b1; digits_in = d; blank_in = b;
    step();
    load = 1'b0;
  endtask

  initial begin
    exp_t e;
    int guard;

    cur_tag = "reset";
    rst = 1'b0; en = 1'b0;
    run(2);
    rst = 1'b1;
    run(1);

    cur_tag = "load1234";
    en = 1'b1;
    pulse_load(16'h1234, 4'h0);
    run(70);

    cur_tag = "async_rst";
    rst = 1'b0;
    #1;
    model_reset();
    e = '{trans: 4'b0, seg: 7'h7F, fd: 1'b0, ack: 1'b0};
    sb_q.push_back(e);
    check_pop();
    @(negedge clk);
    run(1);
    rst = 1'b1;

    cur_tag = "load0070";
    pulse_load(16'h0070, 4'h0);
    run(70);

    cur_tag = "loadAAAA";
    run(9);
    pulse_load(16'hAAAA, 4'h0);
    run_to_boundary();
    run(33);

    cur_tag = "en_drop";
    guard = 0;
    while (k % 8 < 3 && guard < 16) begin
      step();
      guard++;
    end
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(20);

    cur_tag = "boundary_load";
    run_to_boundary();
    pulse_load(16'h5555, 4'h0);
    run(33);

    cur_tag = "blank_lz";
    pulse_load(16'h9000, 4'h1);
    run_to_boundary();
    run(34);

    cur_tag = "all_zero";
    pulse_load(16'h0000, 4'h0);
    run_to_boundary();
    run(34);

    cur_tag = "end";
    chk("sb_empty", 7'(sb_q.size()), 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
